// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - memory access unit: IR/MDR holding and req/ack bus transactions
module mem_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        ir_write,
   input  logic        iord,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] b_reg,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [31:0] mdr,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          ir_ld;
   logic [31:0]   addr;
   logic          req;

   assign addr   = iord ? alu_out : pc;
   assign req    = mem_read ^ mem_write;
   assign busy   = ((state == IDLE) && (mem_read | mem_write)) || (state == REQ);
   assign opcode = ir[6:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ir_ld   <= 1'b0;
         ir      <= 32'h0000_0013;
         mdr     <= 32'h0;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= 32'h0;
         m_wdata <= 32'h0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               // both strobes together is an illegal request: reject without touching the bus
               if (mem_read & mem_write) begin
                  state <= ERR;
                  err   <= 1'b1;
               end else if (req) begin
                  if (addr[1:0] != 2'b00) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else begin
                     m_addr  <= addr;
                     m_we    <= mem_write;
                     m_wdata <= b_reg;
                     ir_ld   <= ir_write & mem_read;
                     m_req   <= 1'b1;
                     cnt     <= '0;
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
               if (m_ack) begin
                  if (!m_we) begin
                     mdr <= m_rdata;
                     if (ir_ld)
                        ir <= m_rdata;
                  end
                  m_req <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  m_req <= 1'b0;
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed-vector bench for mem_unit with TIMEOUT = 4
module tb_mem_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, ir_write, iord;
   logic [31:0] pc, alu_out, b_reg;
   logic        busy, done, err;
   logic [31:0] ir, mdr;
   logic [6:0]  opcode;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_ack;

   int n_run  = 0;
   int n_fail = 0;

   int          req_n, done_at, err_at, busy_n;
   logic [31:0] cap_addr, cap_wdata;
   logic        cap_we, stable;

   mem_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .iord(iord),
      .pc(pc), .alu_out(alu_out), .b_reg(b_reg),
      .busy(busy), .done(done), .err(err),
      .ir(ir), .opcode(opcode), .mdr(mdr),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 is the IDLE cycle the request is presented; ack_cyc < 0 means never.
   task automatic run(input logic rd, input logic wr, input logic irw, input logic io,
                      input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] bv,
                      input int ack_cyc, input logic [31:0] rdv);
      req_n = 0; done_at = -1; err_at = -1; busy_n = 0; stable = 1'b1;
      cap_addr = 32'h0; cap_wdata = 32'h0; cap_we = 1'b0;
      mem_read = rd; mem_write = wr; ir_write = irw; iord = io;
      pc = pcv; alu_out = aluv; b_reg = bv;
      for (int c = 0; c < 20; c++) begin
         if (c == ack_cyc) begin
            m_ack = 1'b1; m_rdata = rdv;
         end else begin
            m_ack = 1'b0; m_rdata = 32'hBAD0_BAD0;
         end
         #1;
         if (busy) busy_n++;
         if (m_req) begin
            if (req_n == 0) begin
               cap_addr = m_addr; cap_we = m_we; cap_wdata = m_wdata;
            end else if (m_addr !== cap_addr || m_we !== cap_we || m_wdata !== cap_wdata) begin
               stable = 1'b0;
            end
            req_n++;
         end
         if (done && done_at < 0) done_at = c;
         if (err && err_at < 0) err_at = c;
         if (done || err) begin
            mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; m_ack = 1'b0;
            tick;
            break;
         end
         tick;
      end
      mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; m_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; iord = 1'b0;
      pc = 32'h0; alu_out = 32'h0; b_reg = 32'h0; m_rdata = 32'h0; m_ack = 1'b0;
      tick; tick;
      chk("rst_ir", ir, 32'h0000_0013);
      chk("rst_opcode", {25'h0, opcode}, 32'h13);
      chk("rst_mdr", mdr, 32'h0);
      chk("rst_out", {27'h0, m_req, m_we, done, err, busy}, 32'h0);
      chk("rst_bus", m_addr | m_wdata, 32'h0);
      rst = 1'b1;
      tick;

      // Fetch, zero wait
      run(1, 0, 1, 0, 32'h10, 32'h0, 32'h0, 1, 32'h00A0_0093);
      chk("fetch_addr", cap_addr, 32'h10);
      chk("fetch_we", {31'h0, cap_we}, 32'h0);
      chk("fetch_done_at", done_at, 2);
      chk("fetch_busy_n", busy_n, 2);
      chk("fetch_ir", ir, 32'h00A0_0093);
      chk("fetch_opcode", {25'h0, opcode}, 32'h13);
      chk("fetch_mdr", mdr, 32'h00A0_0093);
      chk("fetch_idle", {29'h0, done, err, busy}, 32'h0);

      // Load, 3 wait states (ack in the last allowed cycle)
      run(1, 0, 0, 1, 32'h0, 32'h104, 32'h0, 4, 32'hDEAD_BEEF);
      chk("load_addr", cap_addr, 32'h104);
      chk("load_done_at", done_at, 5);
      chk("load_err_at", err_at, -1);
      chk("load_busy_n", busy_n, 5);
      chk("load_req_n", req_n, 4);
      chk("load_mdr", mdr, 32'hDEAD_BEEF);
      chk("load_ir", ir, 32'h00A0_0093);

      // Store, one wait state
      run(0, 1, 0, 1, 32'h0, 32'h200, 32'h1234_5678, 2, 32'hFFFF_FFFF);
      chk("store_addr", cap_addr, 32'h200);
      chk("store_we", {31'h0, cap_we}, 32'h1);
      chk("store_wdata", cap_wdata, 32'h1234_5678);
      chk("store_stable", {31'h0, stable}, 32'h1);
      chk("store_done_at", done_at, 3);
      chk("store_mdr", mdr, 32'hDEAD_BEEF);
      chk("store_ir", ir, 32'h00A0_0093);

      // Misaligned read
      run(1, 0, 0, 1, 32'h0, 32'h102, 32'h0, 1, 32'h1111_1111);
      chk("misal_req_n", req_n, 0);
      chk("misal_err_at", err_at, 1);
      chk("misal_mdr", mdr, 32'hDEAD_BEEF);

      // Illegal: both strobes
      run(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 1, 32'h2222_2222);
      chk("illegal_req_n", req_n, 0);
      chk("illegal_err_at", err_at, 1);
      chk("illegal_done_at", done_at, -1);

      // Timeout, no ack
      run(1, 0, 1, 0, 32'h80, 32'h0, 32'h0, -1, 32'h0);
      chk("tmo_req_n", req_n, 4);
      chk("tmo_err_at", err_at, 5);
      chk("tmo_done_at", done_at, -1);
      chk("tmo_ir", ir, 32'h00A0_0093);
      chk("tmo_idle", {28'h0, m_req, done, err, busy}, 32'h0);

      // Timeout boundary, fetch acked in the 4th request cycle
      run(1, 0, 1, 0, 32'h84, 32'h0, 32'h0, 4, 32'h0010_0113);
      chk("tmo4_req_n", req_n, 4);
      chk("tmo4_done_at", done_at, 5);
      chk("tmo4_err_at", err_at, -1);
      chk("tmo4_ir", ir, 32'h0010_0113);

      // Reset mid-REQ
      mem_read = 1'b1; ir_write = 1'b1; iord = 1'b0; pc = 32'h90; m_ack = 1'b0;
      tick; tick;
      chk("rreq_pre", {31'h0, m_req}, 32'h1);
      #1 rst = 1'b0;
      #1;
      chk("rreq_mreq", {31'h0, m_req}, 32'h0);
      chk("rreq_ir", ir, 32'h0000_0013);
      chk("rreq_mdr", mdr, 32'h0);
      mem_read = 1'b0; ir_write = 1'b0;
      #1 rst = 1'b1;
      m_ack = 1'b1; m_rdata = 32'h5555_5555;
      tick;
      chk("late_ack", {29'h0, m_req, done, err}, 32'h0);
      chk("late_ack_mdr", mdr, 32'h0);
      m_ack = 1'b0;
      tick;
      run(1, 0, 1, 0, 32'h20, 32'h0, 32'h0, 1, 32'h0000_0033);
      chk("post_rst_done_at", done_at, 2);
      chk("post_rst_ir", ir, 32'h0000_0033);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
